// File: rtl/fifo_mem_pkg.sv
// Shared types for the burst memory responder: word width and channel FSM states.
// No logic, no latency, no flow control of its own.
package fifo_mem_pkg;
    localparam int WORD_BITS = 32;

    typedef enum logic {R_IDLE, R_RUN} rd_state_t;
    typedef enum logic {W_IDLE, W_RUN} wr_state_t;
endpackage

// File: rtl/fifo_mem_responder_if.sv
// Read-burst, write-burst and host access signals of the responder.
// Read data is valid/ready, write data is valid/ready, host side is gated by host_ready.
interface fifo_mem_responder_if #(
    parameter int ADDR_BITS = 10
);
    import fifo_mem_pkg::*;

    logic [31:0]           read_addr;
    logic [15:0]           read_count;
    logic                  read_req;
    logic                  read_busy;
    logic [WORD_BITS-1:0]  read_data;
    logic                  read_valid;
    logic                  read_ready;

    logic [31:0]           write_addr;
    logic [15:0]           write_count;
    logic                  write_req;
    logic                  write_busy;
    logic [WORD_BITS-1:0]  write_data;
    logic                  write_valid;
    logic                  write_ready;

    logic [ADDR_BITS-1:0]  host_addr;
    logic [WORD_BITS-1:0]  host_wdata;
    logic                  host_we;
    logic                  host_re;
    logic                  host_ready;
    logic [WORD_BITS-1:0]  host_rdata;
    logic                  host_rvalid;

    modport master (
        output read_addr, read_count, read_req, read_ready,
        output write_addr, write_count, write_req, write_data, write_valid,
        output host_addr, host_wdata, host_we, host_re,
        input  read_busy, read_data, read_valid, write_busy, write_ready,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  read_addr, read_count, read_req, read_ready,
        input  write_addr, write_count, write_req, write_data, write_valid,
        input  host_addr, host_wdata, host_we, host_re,
        output read_busy, read_data, read_valid, write_busy, write_ready,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port word RAM, one write port and one registered read-first read port.
// Read data appears one cycle after re; no backpressure, caller owns port arbitration.
module sdp_ram
    import fifo_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_x,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_BITS-1:0] rdata,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_BITS-1:0] wdata
);
    logic [WORD_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

    // The array carries no initializer so it stays a plain inferred RAM; a zero image is left to the load flow.
    logic unused_init_zero;
    assign unused_init_zero = INIT_ZERO;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Separate processes on the same edge give read-first behaviour on address collision.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_mem_responder.sv
// Word memory serving independent read/write bursts plus a host port when both channels idle.
// First read word 2 cycles after request, then 1/cycle; read_ready stalls via a 2-entry buffer.
module fifo_mem_responder
    import fifo_mem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_x,
    fifo_mem_responder_if.slave  bus
);
    typedef logic [ADDR_BITS-1:0] idx_t;

    rd_state_t            rd_state, rd_state_nxt;
    wr_state_t            wr_state, wr_state_nxt;
    idx_t                 rd_idx, wr_idx;
    logic [15:0]          rd_iss_left, rd_dlv_left, wr_left;
    logic                 rd_inflight;
    logic [1:0]           ob_cnt, ob_cnt_nxt;
    logic [WORD_BITS-1:0] ob_dat0, ob_dat1;
    logic                 host_rvld_q;

    logic                 rd_start, wr_start, rd_pop, rd_issue, wr_fire;
    logic                 host_idle, host_wr, host_rd;
    logic                 ram_re, ram_we;
    idx_t                 ram_raddr, ram_waddr;
    logic [WORD_BITS-1:0] ram_wdata, ram_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.read_addr[1:0], bus.read_addr[31:ADDR_BITS+2],
                                bus.write_addr[1:0], bus.write_addr[31:ADDR_BITS+2]};

    always_comb begin
        rd_state_nxt = rd_state;
        wr_state_nxt = wr_state;
        rd_start   = (rd_state == R_IDLE) && bus.read_req  && (bus.read_count  != 16'd0);
        wr_start   = (wr_state == W_IDLE) && bus.write_req && (bus.write_count != 16'd0);
        rd_pop     = (ob_cnt != 2'd0) && bus.read_ready;
        ob_cnt_nxt = ob_cnt + {1'b0, rd_inflight} - {1'b0, rd_pop};
        // Issue only if the word returning next cycle is guaranteed a buffer slot.
        rd_issue   = rd_start || ((rd_state == R_RUN) && (rd_iss_left != 16'd0) && (ob_cnt_nxt < 2'd2));
        wr_fire    = (wr_state == W_RUN) && bus.write_valid;
        host_idle  = (rd_state == R_IDLE) && (wr_state == W_IDLE) && !bus.read_req && !bus.write_req;
        host_wr    = host_idle && bus.host_we;
        host_rd    = host_idle && bus.host_re && !bus.host_we;

        if (rd_state == R_IDLE) begin
            if (rd_start) rd_state_nxt = R_RUN;
        end else if (rd_pop && (rd_dlv_left == 16'd1)) begin
            rd_state_nxt = R_IDLE;
        end

        if (wr_state == W_IDLE) begin
            if (wr_start) wr_state_nxt = W_RUN;
        end else if (wr_fire && (wr_left == 16'd1)) begin
            wr_state_nxt = W_IDLE;
        end
    end

    assign ram_raddr = rd_start ? bus.read_addr[ADDR_BITS+1:2] :
                       (rd_state == R_RUN) ? rd_idx : bus.host_addr;
    assign ram_re    = rd_issue || host_rd;
    assign ram_we    = wr_fire || host_wr;
    assign ram_waddr = (wr_state == W_RUN) ? wr_idx : bus.host_addr;
    assign ram_wdata = (wr_state == W_RUN) ? bus.write_data : bus.host_wdata;

    sdp_ram #(.ADDR_BITS(ADDR_BITS), .INIT_ZERO(INIT_ZERO)) u_ram (
        .clk   (clk),
        .rst_x (rst_x),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            rd_state    <= R_IDLE;
            rd_idx      <= '0;
            rd_iss_left <= '0;
            rd_dlv_left <= '0;
            rd_inflight <= 1'b0;
            ob_cnt      <= 2'd0;
            ob_dat0     <= '0;
            ob_dat1     <= '0;
        end else begin
            rd_state    <= rd_state_nxt;
            rd_inflight <= rd_issue;
            ob_cnt      <= ob_cnt_nxt;
            if (rd_start) begin
                rd_idx      <= bus.read_addr[ADDR_BITS+1:2] + idx_t'(1);
                rd_iss_left <= bus.read_count - 16'd1;
                rd_dlv_left <= bus.read_count;
            end else begin
                if (rd_issue) begin
                    rd_idx      <= rd_idx + idx_t'(1);
                    rd_iss_left <= rd_iss_left - 16'd1;
                end
                if (rd_pop) rd_dlv_left <= rd_dlv_left - 16'd1;
            end
            // Head always lives in ob_dat0; the returning word lands in the first free slot after the pop shift.
            if (rd_pop) ob_dat0 <= ob_dat1;
            if (rd_inflight) begin
                if (ob_cnt_nxt == 2'd1) ob_dat0 <= ram_rdata;
                else                    ob_dat1 <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wr_state    <= W_IDLE;
            wr_idx      <= '0;
            wr_left     <= '0;
            host_rvld_q <= 1'b0;
        end else begin
            wr_state    <= wr_state_nxt;
            host_rvld_q <= host_rd;
            if (wr_start) begin
                wr_idx  <= bus.write_addr[ADDR_BITS+1:2];
                wr_left <= bus.write_count;
            end else if (wr_fire) begin
                wr_idx  <= wr_idx + idx_t'(1);
                wr_left <= wr_left - 16'd1;
            end
        end
    end

    assign bus.read_busy   = (rd_state == R_RUN);
    assign bus.read_valid  = (ob_cnt != 2'd0);
    assign bus.read_data   = ob_dat0;
    assign bus.write_busy  = (wr_state == W_RUN);
    assign bus.write_ready = (wr_state == W_RUN);
    assign bus.host_ready  = host_idle;
    assign bus.host_rdata  = ram_rdata;
    assign bus.host_rvalid = host_rvld_q;
endmodule

// File: tb/tb_fifo_mem_responder.sv
// Directed bench for fifo_mem_responder: inputs change and outputs are sampled on the falling edge.
module tb_fifo_mem_responder;
    localparam int AB = 10;

    logic clk = 1'b0;
    logic rst_x;
    int   vectors = 0;
    int   miscompares = 0;

    fifo_mem_responder_if #(.ADDR_BITS(AB)) bus ();

    fifo_mem_responder #(.ADDR_BITS(AB), .INIT_ZERO(1'b0)) dut (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [AB-1:0] a, input logic [31:0] d);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    task automatic host_rd(input string tag, input logic [AB-1:0] a, input logic [31:0] exp);
        bus.host_addr = a;
        bus.host_re   = 1'b1;
        @(negedge clk);
        bus.host_re   = 1'b0;
        chk({tag, "_rvalid"}, 32'(bus.host_rvalid), 32'd1);
        chk(tag, bus.host_rdata, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.host_rvalid), 32'd0);
    endtask

    // Eight-word burst from byte address 0 with read_ready held high; expects 0x100+i.
    task automatic read_burst8(input string tag);
        bus.read_addr  = 32'h0;
        bus.read_count = 16'd8;
        bus.read_req   = 1'b1;
        bus.read_ready = 1'b1;
        #1 chk({tag, "_host_blocked"}, 32'(bus.host_ready), 32'd0);
        @(negedge clk);
        bus.read_req = 1'b0;
        chk({tag, "_busy"}, 32'(bus.read_busy), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_valid"}, 32'(bus.read_valid), 32'd1);
            chk({tag, "_data"}, bus.read_data, 32'h100 + 32'(i));
            @(negedge clk);
        end
        chk({tag, "_busy_end"}, 32'(bus.read_busy), 32'd0);
        chk({tag, "_valid_end"}, 32'(bus.read_valid), 32'd0);
    endtask

    initial begin
        int e;
        int k;
        int cyc;

        rst_x            = 1'b0;
        bus.read_addr    = '0;
        bus.read_count   = '0;
        bus.read_req     = 1'b0;
        bus.read_ready   = 1'b0;
        bus.write_addr   = '0;
        bus.write_count  = '0;
        bus.write_req    = 1'b0;
        bus.write_data   = '0;
        bus.write_valid  = 1'b0;
        bus.host_addr    = '0;
        bus.host_wdata   = '0;
        bus.host_we      = 1'b0;
        bus.host_re      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_read_busy",   32'(bus.read_busy),   32'd0);
        chk("rst_read_valid",  32'(bus.read_valid),  32'd0);
        chk("rst_write_busy",  32'(bus.write_busy),  32'd0);
        chk("rst_write_ready", 32'(bus.write_ready), 32'd0);
        chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("rst_read_data",   bus.read_data,        32'd0);
        chk("rst_host_rdata",  bus.host_rdata,       32'd0);
        rst_x = 1'b1;
        #1 chk("rst_host_ready", 32'(bus.host_ready), 32'd1);
        @(negedge clk);

        // Host fill then full-rate burst
        for (int i = 0; i < 8; i++) host_wr(AB'(i), 32'h100 + 32'(i));
        read_burst8("r029");

        // Same burst under a 1,0,0 ready pattern
        bus.read_addr  = 32'h0;
        bus.read_count = 16'd8;
        bus.read_req   = 1'b1;
        bus.read_ready = 1'b0;
        @(negedge clk);
        bus.read_req = 1'b0;
        e = 0; k = 0; cyc = 0;
        while (e < 8 && cyc < 80) begin
            if (bus.read_valid) chk("r030_data", bus.read_data, 32'h100 + 32'(e));
            bus.read_ready = (k % 3 == 0);
            k++;
            if (bus.read_valid && bus.read_ready) e++;
            @(negedge clk);
            cyc++;
        end
        chk("r030_count", 32'(e), 32'd8);
        chk("r030_busy_end", 32'(bus.read_busy), 32'd0);
        chk("r030_valid_end", 32'(bus.read_valid), 32'd0);
        @(negedge clk);
        chk("r030_no_extra", 32'(bus.read_valid), 32'd0);

        // Read-first collision on index 5
        host_wr(AB'(5), 32'h11);
        bus.write_addr  = 32'h14;
        bus.write_count = 16'd1;
        bus.write_req   = 1'b1;
        @(negedge clk);
        bus.write_req   = 1'b0;
        bus.write_valid = 1'b1;
        bus.write_data  = 32'h22;
        bus.read_addr   = 32'h14;
        bus.read_count  = 16'd1;
        bus.read_req    = 1'b1;
        bus.read_ready  = 1'b1;
        @(negedge clk);
        bus.write_valid = 1'b0;
        bus.read_req    = 1'b0;
        chk("r032_wbusy_done", 32'(bus.write_busy), 32'd0);
        @(negedge clk);
        chk("r032_valid", 32'(bus.read_valid), 32'd1);
        chk("r032_old", bus.read_data, 32'h11);
        @(negedge clk);
        chk("r032_rbusy_done", 32'(bus.read_busy), 32'd0);
        host_rd("r032_new", AB'(5), 32'h22);

        // Zero-count read request still blocks and drops a host write
        bus.read_req   = 1'b1;
        bus.read_count = 16'd0;
        bus.host_addr  = AB'(5);
        bus.host_wdata = 32'hBAD;
        bus.host_we    = 1'b1;
        #1 chk("h024_host_ready", 32'(bus.host_ready), 32'd0);
        @(negedge clk);
        bus.read_req = 1'b0;
        bus.host_we  = 1'b0;
        chk("h024_no_busy", 32'(bus.read_busy), 32'd0);
        host_rd("h024_dropped", AB'(5), 32'h22);

        // Second write request and zero-count read during a write burst
        bus.write_addr  = 32'h80;
        bus.write_count = 16'd3;
        bus.write_req   = 1'b1;
        @(negedge clk);
        chk("r034_wbusy", 32'(bus.write_busy), 32'd1);
        chk("r034_wready", 32'(bus.write_ready), 32'd1);
        bus.write_addr  = 32'h100;
        bus.write_count = 16'd9;
        bus.read_req    = 1'b1;
        bus.read_count  = 16'd0;
        bus.write_valid = 1'b1;
        bus.write_data  = 32'hC0;
        @(negedge clk);
        bus.write_req  = 1'b0;
        bus.read_req   = 1'b0;
        bus.write_data = 32'hC1;
        chk("r034_rbusy", 32'(bus.read_busy), 32'd0);
        @(negedge clk);
        bus.write_data = 32'hC2;
        @(negedge clk);
        bus.write_valid = 1'b0;
        chk("r034_wbusy_end", 32'(bus.write_busy), 32'd0);
        chk("r034_wready_end", 32'(bus.write_ready), 32'd0);
        host_rd("r034_w0", AB'(32), 32'hC0);
        host_rd("r034_w1", AB'(33), 32'hC1);
        host_rd("r034_w2", AB'(34), 32'hC2);

        // Asynchronous reset in the middle of a read burst
        host_wr(AB'(5), 32'h105);
        bus.read_addr  = 32'h0;
        bus.read_count = 16'd8;
        bus.read_req   = 1'b1;
        bus.read_ready = 1'b1;
        @(negedge clk);
        bus.read_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("r033_pre", bus.read_data, 32'h100 + 32'(i));
            @(negedge clk);
        end
        #1 rst_x = 1'b0;
        #1;
        chk("r033_busy_async", 32'(bus.read_busy), 32'd0);
        chk("r033_valid_async", 32'(bus.read_valid), 32'd0);
        chk("r033_data_async", bus.read_data, 32'd0);
        @(negedge clk);
        rst_x = 1'b1;
        #1 chk("r033_host_ready", 32'(bus.host_ready), 32'd1);
        @(negedge clk);
        read_burst8("r033_post");

        // Write burst wrapping past the top index, with a one-cycle gap
        bus.write_addr  = 32'hFF8;
        bus.write_count = 16'd4;
        bus.write_req   = 1'b1;
        @(negedge clk);
        bus.write_req   = 1'b0;
        bus.write_valid = 1'b1;
        bus.write_data  = 32'hAAAA0001;
        @(negedge clk);
        bus.write_data  = 32'hAAAA0002;
        @(negedge clk);
        bus.write_valid = 1'b0;
        bus.write_data  = 32'hDEAD0000;
        @(negedge clk);
        chk("r031_gap_busy", 32'(bus.write_busy), 32'd1);
        bus.write_valid = 1'b1;
        bus.write_data  = 32'hAAAA0003;
        @(negedge clk);
        bus.write_data  = 32'hAAAA0004;
        @(negedge clk);
        chk("r031_busy_end", 32'(bus.write_busy), 32'd0);
        chk("r031_ready_end", 32'(bus.write_ready), 32'd0);
        // write_valid stays high one idle cycle with junk data; it must not land anywhere
        bus.write_data = 32'hDEAD0001;
        @(negedge clk);
        bus.write_valid = 1'b0;
        host_rd("r031_idx1022", AB'(1022), 32'hAAAA0001);
        host_rd("r031_idx1023", AB'(1023), 32'hAAAA0002);
        host_rd("r031_idx0",    AB'(0),    32'hAAAA0003);
        host_rd("r031_idx1",    AB'(1),    32'hAAAA0004);
        host_rd("r031_idx2",    AB'(2),    32'h102);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
